// File: rtl/axi_r_alloc_pkg.sv
// ============================================================================
// axi_r_alloc_pkg : shared types and constants for the AXI R-channel allocator
// Revision: 1.0
// ============================================================================
`default_nettype none

package axi_r_alloc_pkg;

  typedef enum logic [1:0] {
    OPERATIVE  = 2'd0,
    WAIT_DRAIN = 2'd1,
    ERROR      = 2'd2
  } alloc_state_e;

  localparam logic [31:0] DECERR_PATTERN = 32'hDEADBEEF;
  localparam logic [1:0]  RESP_DECERR    = 2'b11;

endpackage

`default_nettype wire

// File: rtl/axi_r_err_fifo.sv
// ============================================================================
// axi_r_err_fifo : small queue of pending DECERR bursts (caller qualifies push)
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_r_err_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             last_entry
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head       = r_mem[r_rd_ptr];
  assign full       = (r_count == CNT_W'(DEPTH));
  assign empty      = (r_count == '0);
  assign last_entry = (r_count == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/axi_r_resp_allocator.sv
// ============================================================================
// axi_r_resp_allocator : burst-locked round-robin R allocator with DECERR queue
// Optional stall counter output under `AXI_R_ALLOC_STALL_CNT_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module axi_r_resp_allocator
  import axi_r_alloc_pkg::*;
#(
  parameter int AXI_USER_W  = 6,
  parameter int N_INIT_PORT = 4,
  parameter int N_TARG_PORT = 7,
  parameter int AXI_DATA_W  = 64,
  parameter int AXI_ID_IN   = 16,
  parameter int AXI_ID_OUT  = AXI_ID_IN + $clog2(N_TARG_PORT),
  parameter int OUTST_W     = 10,
  parameter int ERR_DEPTH   = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [N_INIT_PORT-1:0][AXI_ID_OUT-1:0]  rid_i,
  input  logic [N_INIT_PORT-1:0][AXI_DATA_W-1:0]  rdata_i,
  input  logic [N_INIT_PORT-1:0][1:0]             rresp_i,
  input  logic [N_INIT_PORT-1:0]                  rlast_i,
  input  logic [N_INIT_PORT-1:0][AXI_USER_W-1:0]  ruser_i,
  input  logic [N_INIT_PORT-1:0]                  rvalid_i,
  output logic [N_INIT_PORT-1:0]                  rready_o,
  output logic [AXI_ID_IN-1:0]                    rid_o,
  output logic [AXI_DATA_W-1:0]                   rdata_o,
  output logic [1:0]                              rresp_o,
  output logic                                    rlast_o,
  output logic [AXI_USER_W-1:0]                   ruser_o,
  output logic                                    rvalid_o,
  input  logic                                    rready_i,
  input  logic                                    incr_req_i,
  output logic                                    full_counter_o,
  output logic                                    outstanding_trans_o,
  input  logic                                    error_req_i,
  input  logic [7:0]                              error_len_i,
  input  logic [AXI_USER_W-1:0]                   error_user_i,
  input  logic [AXI_ID_IN-1:0]                    error_id_i,
  output logic                                    error_full_o,
  output logic                                    error_gnt_o
`ifdef AXI_R_ALLOC_STALL_CNT_EN
  ,
  output logic [31:0]                             stall_cnt_o
`endif
);

  localparam int SEL_W = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;

  typedef struct packed {
    logic [AXI_ID_IN-1:0]  id;
    logic [AXI_USER_W-1:0] user;
    logic [7:0]            len;
  } err_entry_t;

  alloc_state_e     r_state, w_state_nxt;
  logic [SEL_W-1:0] w_grant, r_lock_idx;
  logic             r_lock;
  logic [OUTST_W-1:0] r_outst;
  logic [7:0]       r_beat;
  err_entry_t       w_err_in, w_err_head;
  logic             w_err_empty, w_err_last_entry, w_err_push, w_err_pop;
  logic             w_route_en, w_gvalid, w_r_hs, w_r_last_hs, w_e_hs, w_e_last_hs;
  logic             w_unused;

  // Only the low AXI_ID_IN bits of each input ID are forwarded.
  assign w_unused = &{1'b0, rid_i};

  generate
    if (N_INIT_PORT > 1) begin : g_rr
      logic [SEL_W-1:0] r_ptr;
      logic [SEL_W-1:0] w_rr_sel;

      // Descending scan so the first valid port at or after r_ptr wins.
      always_comb begin
        int idx;
        w_rr_sel = r_ptr;
        for (int k = N_INIT_PORT - 1; k >= 0; k--) begin
          idx = int'(r_ptr) + k;
          if (idx >= N_INIT_PORT) idx = idx - N_INIT_PORT;
          if (rvalid_i[idx]) w_rr_sel = SEL_W'(idx);
        end
      end

      assign w_grant = r_lock ? r_lock_idx : w_rr_sel;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ptr <= '0;
        else if (w_r_last_hs)
          r_ptr <= (w_grant == SEL_W'(N_INIT_PORT - 1)) ? '0 : w_grant + 1'b1;
      end
    end else begin : g_direct
      assign w_grant = '0;
    end
  endgenerate

  assign w_route_en  = (r_state != ERROR);
  assign w_gvalid    = rvalid_i[w_grant];
  assign w_r_hs      = w_route_en && w_gvalid && rready_i;
  assign w_r_last_hs = w_r_hs && rlast_i[w_grant];

  assign w_e_hs      = (r_state == ERROR) && rready_i;
  assign w_e_last_hs = w_e_hs && (r_beat == w_err_head.len);
  assign w_err_pop   = w_e_last_hs;
  assign w_err_push  = error_req_i && (!error_full_o || w_err_pop);

  always_comb begin
    w_err_in      = '0;
    w_err_in.id   = error_id_i;
    w_err_in.user = error_user_i;
    w_err_in.len  = error_len_i;
  end

  axi_r_err_fifo #(
    .DEPTH (ERR_DEPTH),
    .WIDTH ($bits(err_entry_t))
  ) u_err_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_err_push),
    .pop        (w_err_pop),
    .wdata      (w_err_in),
    .head       (w_err_head),
    .full       (error_full_o),
    .empty      (w_err_empty),
    .last_entry (w_err_last_entry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= OPERATIVE;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_outst    <= '0;
      r_beat     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_r_hs) begin
        r_lock     <= !rlast_i[w_grant];
        r_lock_idx <= w_grant;
      end
      case ({incr_req_i, w_r_last_hs})
        2'b10:   if (!(&r_outst)) r_outst <= r_outst + 1'b1;
        2'b01:   if (|r_outst)    r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
      if (w_e_last_hs) r_beat <= '0;
      else if (w_e_hs) r_beat <= r_beat + 8'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      OPERATIVE:  if (!w_err_empty) w_state_nxt = WAIT_DRAIN;
      WAIT_DRAIN: if ((r_outst == '0) && !r_lock && !w_gvalid) w_state_nxt = ERROR;
      ERROR:
        if (w_e_last_hs)
          w_state_nxt = (!w_err_last_entry || w_err_push) ? WAIT_DRAIN : OPERATIVE;
      default:    w_state_nxt = OPERATIVE;
    endcase
  end

  always_comb begin
    rready_o = '0;
    rvalid_o = 1'b0;
    rid_o    = '0;
    rdata_o  = '0;
    rresp_o  = '0;
    rlast_o  = 1'b0;
    ruser_o  = '0;
    if (w_route_en && rready_i) rready_o[w_grant] = w_gvalid;
    if (r_state == ERROR) begin
      rvalid_o = 1'b1;
      rid_o    = w_err_head.id;
      ruser_o  = w_err_head.user;
      rresp_o  = RESP_DECERR;
      rdata_o  = {(AXI_DATA_W / 32){DECERR_PATTERN}};
      rlast_o  = (r_beat == w_err_head.len);
    end else if (w_gvalid) begin
      rvalid_o = 1'b1;
      rid_o    = rid_i[w_grant][AXI_ID_IN-1:0];
      ruser_o  = ruser_i[w_grant];
      rresp_o  = rresp_i[w_grant];
      rdata_o  = rdata_i[w_grant];
      rlast_o  = rlast_i[w_grant];
    end
  end

  assign error_gnt_o         = w_e_last_hs;
  assign full_counter_o      = &r_outst;
  assign outstanding_trans_o = |r_outst;

`ifdef AXI_R_ALLOC_STALL_CNT_EN
  logic [31:0] r_stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stall <= '0;
    else if (rvalid_o && !rready_i && !(&r_stall)) r_stall <= r_stall + 32'd1;
  end
  assign stall_cnt_o = r_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_r_resp_allocator.sv
// ============================================================================
// tb_axi_r_resp_allocator : directed self-checking bench for the R allocator
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi_r_resp_allocator;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int IDI = 16;
  localparam int IDO = 19;
  localparam int UW  = 6;
  localparam logic [63:0] DB = 64'hDEADBEEF_DEADBEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0][IDO-1:0] rid_i;
  logic [N-1:0][DW-1:0]  rdata_i;
  logic [N-1:0][1:0]     rresp_i;
  logic [N-1:0]          rlast_i;
  logic [N-1:0][UW-1:0]  ruser_i;
  logic [N-1:0]          rvalid_i;
  logic [N-1:0]          rready_o;
  logic [IDI-1:0]        rid_o;
  logic [DW-1:0]         rdata_o;
  logic [1:0]            rresp_o;
  logic                  rlast_o;
  logic [UW-1:0]         ruser_o;
  logic                  rvalid_o;
  logic                  rready_i;
  logic                  incr_req_i;
  logic                  full_counter_o;
  logic                  outstanding_trans_o;
  logic                  error_req_i;
  logic [7:0]            error_len_i;
  logic [UW-1:0]         error_user_i;
  logic [IDI-1:0]        error_id_i;
  logic                  error_full_o;
  logic                  error_gnt_o;
`ifdef AXI_R_ALLOC_STALL_CNT_EN
  logic [31:0]           stall_cnt;
`endif

  axi_r_resp_allocator dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rid_i               (rid_i),
    .rdata_i             (rdata_i),
    .rresp_i             (rresp_i),
    .rlast_i             (rlast_i),
    .ruser_i             (ruser_i),
    .rvalid_i            (rvalid_i),
    .rready_o            (rready_o),
    .rid_o               (rid_o),
    .rdata_o             (rdata_o),
    .rresp_o             (rresp_o),
    .rlast_o             (rlast_o),
    .ruser_o             (ruser_o),
    .rvalid_o            (rvalid_o),
    .rready_i            (rready_i),
    .incr_req_i          (incr_req_i),
    .full_counter_o      (full_counter_o),
    .outstanding_trans_o (outstanding_trans_o),
    .error_req_i         (error_req_i),
    .error_len_i         (error_len_i),
    .error_user_i        (error_user_i),
    .error_id_i          (error_id_i),
    .error_full_o        (error_full_o),
    .error_gnt_o         (error_gnt_o)
`ifdef AXI_R_ALLOC_STALL_CNT_EN
    ,
    .stall_cnt_o         (stall_cnt)
`endif
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int gnt_cnt = 0;
  int src_len [N];
  int src_idx [N];

  logic [63:0]  log_data [$];
  logic [15:0]  log_id   [$];
  logic         log_last [$];
  logic [1:0]   log_resp [$];

  logic [63:0] e_t1  [8] = '{64'h000, 64'h001, 64'h002, 64'h003,
                             64'h200, 64'h201, 64'h202, 64'h203};
  logic [63:0] e_ptr [3] = '{64'h300, 64'h000, 64'h100};
  logic [63:0] e_t2  [5] = '{64'h100, 64'h101, 64'h102, 64'h103, 64'h300};
  logic [63:0] e_t3d [7] = '{64'h000, 64'h001, 64'h100, 64'h200, DB, DB, DB};
  logic [15:0] e_t3i [7] = '{16'h100, 16'h100, 16'h101, 16'h102, 16'd5, 16'd5, 16'd5};
  logic        e_t3l [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_port(input int p);
    rid_i[p]   = {3'(p), 16'(16'h0100 + p)};
    rdata_i[p] = 64'(p * 256 + src_idx[p]);
    rlast_i[p] = (src_idx[p] == src_len[p] - 1);
    ruser_i[p] = UW'(p);
    rresp_i[p] = 2'b00;
  endtask

  task automatic start_burst(input int p, input int n);
    src_len[p]  = n;
    src_idx[p]  = 0;
    rvalid_i[p] = 1'b1;
    drive_port(p);
  endtask

  task automatic clear_log();
    log_data.delete();
    log_id.delete();
    log_last.delete();
    log_resp.delete();
    gnt_cnt = 0;
  endtask

  // Observe the cycle mid-period, cross the edge, then advance each source.
  task automatic tick();
    logic [N-1:0] hs;
    #3;
    hs = rvalid_i & rready_o;
    if (rvalid_o && rready_i) begin
      log_data.push_back(rdata_o);
      log_id.push_back(rid_o);
      log_last.push_back(rlast_o);
      log_resp.push_back(rresp_o);
    end
    if (error_gnt_o) gnt_cnt++;
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (hs[p]) begin
        src_idx[p]++;
        if (src_idx[p] >= src_len[p]) begin
          rvalid_i[p] = 1'b0;
          rlast_i[p]  = 1'b0;
        end else begin
          drive_port(p);
        end
      end
    end
    #1;
  endtask

  initial begin
    rid_i = '0; rdata_i = '0; rresp_i = '0; rlast_i = '0; ruser_i = '0; rvalid_i = '0;
    rready_i = 1'b0; incr_req_i = 1'b0; error_req_i = 1'b0; error_len_i = '0;
    error_user_i = '0; error_id_i = '0;
    for (int p = 0; p < N; p++) begin src_len[p] = 0; src_idx[p] = 0; end

    repeat (2) @(posedge clk);
    #1;
    check("rst_rvalid", rvalid_o, 0);
    check("rst_rready", rready_o, 0);
    rst_n = 1'b1;
    #1;
    check("rst_full_cnt", full_counter_o, 0);
    check("rst_outst", outstanding_trans_o, 0);
    check("rst_err_full", error_full_o, 0);
    check("rst_err_gnt", error_gnt_o, 0);
    check("rst_rdata", rdata_o, 0);

    // Two simultaneous 4-beat bursts: port 0 fully first, then port 2.
    clear_log();
    rready_i = 1'b1;
    start_burst(0, 4);
    start_burst(2, 4);
    for (int t = 0; t < 20 && log_data.size() < 8; t++) tick();
    check("t1_count", log_data.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("t1_data%0d", i), log_data[i], e_t1[i]);
    check("t1_rid_stripped", log_id[4], 16'h0102);

    // Pointer now at 3: ports 0,1,3 together are served 3,0,1.
    clear_log();
    start_burst(0, 1);
    start_burst(1, 1);
    start_burst(3, 1);
    for (int t = 0; t < 12 && log_data.size() < 3; t++) tick();
    for (int i = 0; i < 3; i++) check($sformatf("ptr_data%0d", i), log_data[i], e_ptr[i]);

    // Burst lock with rready toggling while port 3 competes.
    clear_log();
    start_burst(1, 4);
    tick();
    start_burst(3, 1);
    for (int t = 0; t < 24 && log_data.size() < 5; t++) begin
      rready_i = t[0];
      tick();
    end
    check("t2_count", log_data.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("t2_data%0d", i), log_data[i], e_t2[i]);
    check("t2_last3", log_last[3], 1);

    // Outstanding reads must drain before the queued DECERR burst.
    clear_log();
    rready_i = 1'b1;
    incr_req_i = 1'b1;
    repeat (3) tick();
    incr_req_i = 1'b0;
    check("t3_outst", outstanding_trans_o, 1);
    error_req_i = 1'b1; error_len_i = 8'd2; error_id_i = 16'd5; error_user_i = 6'h2A;
    tick();
    error_req_i = 1'b0;
    repeat (3) tick();
    check("t3_wait_rvalid", rvalid_o, 0);
    start_burst(0, 2);
    start_burst(1, 1);
    start_burst(2, 1);
    for (int t = 0; t < 40 && log_data.size() < 7; t++) tick();
    repeat (3) tick();
    check("t3_count", log_data.size(), 7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t3_data%0d", i), log_data[i], e_t3d[i]);
      check($sformatf("t3_id%0d", i), log_id[i], e_t3i[i]);
      check($sformatf("t3_last%0d", i), log_last[i], e_t3l[i]);
    end
    check("t3_resp", log_resp[5], 2'b11);
    check("t3_gnt", gnt_cnt, 1);
    check("t3_outst_end", outstanding_trans_o, 0);

    // Five pushes into a 4-deep queue with the target stalled.
    clear_log();
    rready_i = 1'b0;
    error_req_i = 1'b1; error_len_i = 8'd0;
    for (int k = 0; k < 4; k++) begin
      error_id_i = 16'(10 + k);
      tick();
    end
    check("t4_full4", error_full_o, 1);
    error_id_i = 16'd14;
    tick();
    error_req_i = 1'b0;
    check("t4_full5", error_full_o, 1);
    rready_i = 1'b1;
    for (int t = 0; t < 40 && log_data.size() < 4; t++) tick();
    repeat (10) tick();
    check("t4_count", log_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_id%0d", i), log_id[i], 16'(10 + i));
      check($sformatf("t4_last%0d", i), log_last[i], 1);
    end
    check("t4_gnt", gnt_cnt, 4);
    check("t4_full_end", error_full_o, 0);

    // Increment and routed-last in the same cycle hold the counter at 1.
    clear_log();
    incr_req_i = 1'b1;
    tick();
    start_burst(0, 1);
    tick();
    incr_req_i = 1'b0;
    check("t5_hold_outst", outstanding_trans_o, 1);
    start_burst(0, 1);
    tick();
    check("t5_drained", outstanding_trans_o, 0);

    // Reset during beat 2 of a 4-beat DECERR burst.
    clear_log();
    error_req_i = 1'b1; error_len_i = 8'd3; error_id_i = 16'd7;
    tick();
    error_req_i = 1'b0;
    for (int t = 0; t < 20 && log_data.size() < 1; t++) tick();
    check("t6_beat2_valid", rvalid_o, 1);
    check("t6_beat2_last", rlast_o, 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_rvalid", rvalid_o, 0);
    check("t6_rst_rdata", rdata_o, 0);
    check("t6_rst_rid", rid_o, 0);
    check("t6_rst_gnt", error_gnt_o, 0);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("t6_no_replay", log_data.size(), 1);
    check("t6_gnt", gnt_cnt, 0);
    check("t6_rvalid_after", rvalid_o, 0);

    // Counter saturation at all-ones.
    incr_req_i = 1'b1;
    repeat (1022) tick();
    check("t7_not_full", full_counter_o, 0);
    tick();
    check("t7_full", full_counter_o, 1);
    tick();
    incr_req_i = 1'b0;
    check("t7_saturated", full_counter_o, 1);
    start_burst(0, 1);
    tick();
    check("t7_dec_full", full_counter_o, 0);
    check("t7_dec_outst", outstanding_trans_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_r_resp_allocator.md
Name: axi_r_resp_allocator

Overview:
- Next-generation backward read-data (R) allocator for the AXI node.
- Arbitrates R beats from N_INIT_PORT initiator-side ports onto one target-side R channel; strips the routing ID bits; locks the grant for a whole burst.
- Generates DECERR read responses for unmapped requests from an ERR_DEPTH-deep queue instead of a single sampled slot.
- Tracks outstanding routed reads with a parametrised saturating counter.

Parameters:
- AXI_USER_W, 6, R user width.
- N_INIT_PORT, 4, number of initiator ports; must be >= 1.
- N_TARG_PORT, 7, target port count; sets ID extension.
- AXI_DATA_W, 64, data width; multiple of 32.
- AXI_ID_IN, 16, ID width on the output side.
- AXI_ID_OUT, AXI_ID_IN+$clog2(N_TARG_PORT), ID width on the inputs.
- OUTST_W, 10, outstanding counter width.
- ERR_DEPTH, 4, error queue entries; must be >= 1.

Ports:
- clk in 1 clock.
- rst_n in 1 asynchronous active-low reset.
- rid_i in N_INIT_PORT x AXI_ID_OUT: input IDs.
- rdata_i in N_INIT_PORT x AXI_DATA_W: input data.
- rresp_i in N_INIT_PORT x 2: input response codes.
- rlast_i in N_INIT_PORT x 1: last beat of burst.
- ruser_i in N_INIT_PORT x AXI_USER_W: input user bits.
- rvalid_i in N_INIT_PORT: input valids.
- rready_o out N_INIT_PORT: ready back to each port.
- rid_o out AXI_ID_IN: output ID.
- rdata_o out AXI_DATA_W: output data.
- rresp_o out 2: output response code.
- rlast_o out 1: output last.
- ruser_o out AXI_USER_W: output user bits.
- rvalid_o out 1: output valid.
- rready_i in 1: output ready.
- incr_req_i in 1: one routed AR accepted.
- full_counter_o out 1: outstanding counter all-ones.
- outstanding_trans_o out 1: outstanding counter non-zero.
- error_req_i in 1: push one error entry.
- error_len_i in 8: error burst length (beats-1).
- error_user_i in AXI_USER_W: error user bits.
- error_id_i in AXI_ID_IN: error ID.
- error_full_o out 1: error queue full.
- error_gnt_o out 1: error burst completed.

Behaviour:
- Reset: all outputs 0; counter 0; queue empty; FSM OPERATIVE; RR pointer at 0; lock clear.
- Routed path is combinational, zero latency: rid_o = granted rid_i[AXI_ID_IN-1:0].
- Arbitration:
  - Round-robin starting at the pointer.
  - Once a non-last beat handshakes, the grant locks to that port until its rlast beat handshakes.
  - The pointer moves to grant+1 (mod N) on the last-beat handshake.
  - rready_o is high only for the granted port, and only while rready_i is high in OPERATIVE or WAIT_DRAIN.
  - N_INIT_PORT=1: direct pass, no pointer.
- Counter:
  - incr only: +1, saturating at all-ones.
  - Routed-last handshake only: -1, saturating at 0.
  - Both in the same cycle: hold.
  - Error beats never decrement.
- Error queue:
  - Push when error_req_i && !error_full_o; push while full is dropped.
  - error_full_o = (count == ERR_DEPTH), combinational.
  - Push and pop in the same cycle is allowed when full.
- FSM:
  - OPERATIVE: queue non-empty -> WAIT_DRAIN.
  - WAIT_DRAIN: routed traffic continues. Go to ERROR when counter == 0, lock clear, and no routed beat is pending handshake this cycle. Routed incr_req_i still counts.
  - ERROR:
    - rready_o = 0.
    - rvalid_o = 1; rresp_o = DECERR; rdata_o = 32'hDEADBEEF replicated; id/user from the queue head.
    - Beat counter (8 bit) increments per rready_i.
    - rlast_o = (beat == head.len).
    - Last handshake pops the head, pulses error_gnt_o for 1 cycle, clears the beat counter, and goes to WAIT_DRAIN if more entries remain, else OPERATIVE.
- len = 0: a single beat with rlast_o = 1.
- Reset mid-burst: state discarded immediately; no beats replayed.

Optional Feature:
- Macro: AXI_R_ALLOC_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o, 32 bits, reset 0.
  - Increments each cycle rvalid_o && !rready_i; saturates at all-ones.
- Undefined: port and counter absent; otherwise identical behaviour.

Decomposition:
- Package axi_r_alloc_pkg:
  - FSM state enum {OPERATIVE, WAIT_DRAIN, ERROR}.
  - Parametrised error-entry struct {id, user, len}, via typedef in the module using pkg widths.
  - DECERR_PATTERN constant 32'hDEADBEEF.
- Sub-module axi_r_err_fifo: the error queue (push/pop/full/empty/head).
- Arbiter lives inline.

Test Plan:
- N_INIT_PORT=4; ports 0 and 2 present 4-beat bursts simultaneously, rready_i=1 -> 4 port-0 beats contiguous, then 4 port-2 beats; no interleave; pointer=3 after.
- rready_i toggled 1/0 during a port-1 burst while port-3 is valid -> no beat from port 3 until the port-1 rlast handshake.
- 3 incr_req_i, then error_req_i len=2 id=5 -> routed returns continue; after the third routed rlast, 3 DECERR beats with rid_o=5, last on the third; error_gnt_o pulses once.
- ERR_DEPTH=4, 5 error pushes with counter 0 -> error_full_o high after the 4th; 5th dropped; exactly 4 error bursts emitted.
- incr_req_i and a routed-last handshake in the same cycle at counter 1 -> counter stays 1. With OUTST_W=2, 4 incr -> full_counter_o=1, saturates at 3.
- rst_n low during error beat 2 of 4 -> all outputs 0 next edge; queue empty; no error_gnt_o.
